// File: rtl/sequential_divider.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Shares the start / end-pulse handshake of the sequential multiplier; a zero divisor is flagged, not iterated.
module sequential_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 end_div,
  output logic [2*WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] q_work_q, q_work_d;
  logic [WIDTH:0]     r_work_q, r_work_d;
  logic [WIDTH-1:0]   d_reg_q, d_reg_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               end_div_q, end_div_d;
  logic [2*WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_by_zero_q, div_by_zero_d;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               fits;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    q_work_d      = q_work_q;
    r_work_d      = r_work_q;
    d_reg_d       = d_reg_q;
    zero_d        = zero_q;
    end_div_d     = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    // Partial remainder shifted left with the next dividend bit brought in
    trial = {r_work_q[WIDTH-1:0], q_work_q[2*WIDTH-1]};
    diff  = trial - {1'b0, d_reg_q};
    fits  = (trial >= {1'b0, d_reg_q});

    case (state_q)
      IDLE: begin
        if (start) begin
          q_work_d = dividend;
          d_reg_d  = divisor;
          r_work_d = '0;
          if (divisor != '0) begin
            zero_d  = 1'b0;
            count_d = CNT_W'(2 * WIDTH);
            state_d = CALC;
          end else begin
            zero_d  = 1'b1;
            count_d = '0;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        q_work_d = {q_work_q[2*WIDTH-2:0], fits};
        r_work_d = fits ? diff : trial;
        count_d  = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        end_div_d = 1'b1;
        state_d   = IDLE;
        // The low dividend half still sits in q_work when the divisor was zero
        if (zero_q) begin
          quotient_d    = '1;
          remainder_d   = q_work_q[WIDTH-1:0];
          div_by_zero_d = 1'b1;
        end else begin
          quotient_d    = q_work_q;
          remainder_d   = r_work_q[WIDTH-1:0];
          div_by_zero_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      q_work_q      <= '0;
      r_work_q      <= '0;
      d_reg_q       <= '0;
      zero_q        <= 1'b0;
      busy_q        <= 1'b0;
      end_div_q     <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      q_work_q      <= q_work_d;
      r_work_q      <= r_work_d;
      d_reg_q       <= d_reg_d;
      zero_q        <= zero_d;
      busy_q        <= busy_d;
      end_div_q     <= end_div_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign end_div     = end_div_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider (WIDTH=32): handshake, latency, boundary operands, reset abort.
module tb_sequential_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        end_div;
  logic [63:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int total_checks = 0;
  int bad_checks   = 0;

  sequential_divider #(.WIDTH(32), .CNT_W(7)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .end_div     (end_div),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Present operands with start for exactly one accepting edge
  task automatic applyStimulus(input logic [63:0] dvd, input logic [31:0] dvs);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic waitEnd(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clock);
      #1;
      if (end_div) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic [63:0] dvd, input logic [31:0] dvs,
                       input logic [63:0] exp_q, input logic [31:0] exp_r, input logic exp_z,
                       input int exp_lat);
    int lat;
    applyStimulus(dvd, dvs);
    waitEnd(lat);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_quotient"}, quotient, exp_q);
    checkOutput({tag, "_remainder"}, {32'd0, remainder}, {32'd0, exp_r});
    checkOutput({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_z});
    checkOutput({tag, "_busy_at_end"}, {63'd0, busy}, 64'd0);
    @(posedge clock);
    #1;
    checkOutput({tag, "_end_cleared"}, {63'd0, end_div}, 64'd0);
    checkOutput({tag, "_quotient_held"}, quotient, exp_q);
  endtask

  initial begin
    int lat;
    int seen;
    logic busy_dropped;
    logic [63:0] rd;
    logic [31:0] rs;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_quotient", quotient, 64'd0);
    checkOutput("reset_remainder", {32'd0, remainder}, 64'd0);
    checkOutput("reset_flags", {61'd0, busy, end_div, div_by_zero}, 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    runOp("basic", 64'd100, 32'd7, 64'd14, 32'd2, 1'b0, 65);
    runOp("max_div", 64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFF, 64'h00000001_00000001, 32'd0, 1'b0, 65);
    runOp("div_one", 64'hFFFFFFFF_FFFFFFFF, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 32'd0, 1'b0, 65);
    runOp("small", 64'd5, 32'd9, 64'd0, 32'd5, 1'b0, 65);
    runOp("zero_div", 64'h12345678_9ABCDEF0, 32'd0, 64'hFFFFFFFF_FFFFFFFF, 32'h9ABCDEF0, 1'b1, 1);
    runOp("after_zero", 64'd1000, 32'd3, 64'd333, 32'd1, 1'b0, 65);

    // start held high; operands scrambled while busy must be ignored
    start    = 1'b1;
    dividend = 64'd1000;
    divisor  = 32'd10;
    @(posedge clock);
    #1;
    lat = -1;
    busy_dropped = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (!busy) busy_dropped = 1'b1;
      dividend = {$urandom, $urandom};
      divisor  = $urandom;
      @(posedge clock);
      #1;
      if (end_div) begin
        lat = k;
        break;
      end
    end
    checkOutput("held_latency", 64'(lat), 64'd65);
    checkOutput("held_busy_during_calc", {63'd0, busy_dropped}, 64'd0);
    checkOutput("held_quotient", quotient, 64'd100);
    checkOutput("held_remainder", {32'd0, remainder}, 64'd0);
    checkOutput("held_busy_at_end", {63'd0, busy}, 64'd0);
    dividend = 64'd200;
    divisor  = 32'd3;
    @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput("b2b_end_cleared", {63'd0, end_div}, 64'd0);
    checkOutput("b2b_busy_again", {63'd0, busy}, 64'd1);
    waitEnd(lat);
    checkOutput("b2b_latency", 64'(lat), 64'd65);
    checkOutput("b2b_quotient", quotient, 64'd66);
    checkOutput("b2b_remainder", {32'd0, remainder}, 64'd2);
    @(posedge clock);
    #1;

    // Reset in the middle of CALC discards the operation
    applyStimulus(64'd100, 32'd7);
    repeat (29) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("abort_quotient", quotient, 64'd0);
    checkOutput("abort_remainder", {32'd0, remainder}, 64'd0);
    checkOutput("abort_flags", {61'd0, busy, end_div, div_by_zero}, 64'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clock);
      #1;
      if (end_div) seen++;
    end
    checkOutput("abort_no_end", 64'(seen), 64'd0);
    runOp("after_abort", 64'd81, 32'd9, 64'd9, 32'd0, 1'b0, 65);

    // Mixed operands: zero divisors, divisor larger than dividend, full-range values
    for (int i = 0; i < 200; i++) begin
      case (i % 4)
        0:       begin rd = {$urandom, $urandom}; rs = (i % 8 == 0) ? 32'd0 : $urandom; end
        1:       begin rd = 64'($urandom_range(0, 1000)); rs = $urandom | 32'h0000_4000; end
        2:       begin rd = {$urandom, $urandom}; rs = 32'($urandom_range(1, 255)); end
        default: begin rd = {$urandom, $urandom}; rs = $urandom; end
      endcase
      if (rs == 32'd0) begin
        runOp("rand_zero", rd, rs, 64'hFFFFFFFF_FFFFFFFF, rd[31:0], 1'b1, 1);
      end else begin
        runOp("rand", rd, rs, rd / {32'd0, rs}, 32'(rd % {32'd0, rs}), 1'b0, 65);
      end
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
